wb_commit_trace: RTL
====================

Name: wb_commit_trace

Overview:
- Synthesizable commit-trace capture unit sitting directly downstream of the openmips core's writeback stage.
- Taps the same writeback signals the CPU bench checks: register write enable/index/data and HI/LO write enable/data.
- Serialises each commit event into a cycle-stamped FIFO entry.
- Presents entries on a valid/ready stream so a bench, or later a debug UART, can drain the architectural-write trace without probing core internals.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CYCLE_W, 32, width of cycle stamp counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- clear_i  in  1  synchronous flush of FIFO, counters and flags.
- wb_wreg_i  in  1  GPR write enable from writeback.
- wb_wd_i  in  5  GPR write index.
- wb_wdata_i  in  32  GPR write data.
- wb_whilo_i  in  1  HI/LO write enable.
- wb_hi_i  in  32  HI data.
- wb_lo_i  in  32  LO data.
- trace_valid_o  out  1  head entry available.
- trace_ready_i  in  1  consumer accepts head.
- trace_kind_o  out  2  head kind: 2'd1 = REG, 2'd2 = HILO.
- trace_wd_o  out  5  head GPR index; 0 for HILO.
- trace_data_o  out  64  REG: {32'h0, wdata}; HILO: {hi, lo}.
- trace_cycle_o  out  CYCLE_W  cycle stamp of head.
- overflow_o  out  1  sticky: at least one event dropped.
- drop_cnt_o  out  16  saturating count of dropped events.

Behaviour:
- Reset (rst = 1): FIFO empty, trace_valid_o = 0, all data outputs 0, overflow_o = 0, drop_cnt_o = 0, cycle counter = 0.
- Priority: rst > clear_i > normal operation. clear_i has the same effect as rst for one cycle.
- Cycle counter:
  - Increments by 1 every non-reset, non-clear cycle.
  - Wraps modulo 2^CYCLE_W.
  - An event captured in a cycle is stamped with the counter value in that cycle, before the increment. The first cycle after reset stamps 0.
- Event qualification, sampled at posedge:
  - REG event = wb_wreg_i && wb_wd_i != 0. Writes to $0 are silently ignored and are not counted as drops.
  - HILO event = wb_whilo_i.
  - Both events may occur in the same cycle.
- Push:
  - free = DEPTH - count, using the registered count. A pop in the same cycle does not free space for that cycle's push; there is no pass-through.
  - Two events with free >= 2: write REG at tail, then HILO at tail+1. Both carry the same stamp.
  - Two events with free == 1: write REG only, drop HILO.
  - free == 0: drop every event.
  - Each dropped event sets overflow_o and increments drop_cnt_o, which saturates at 16'hFFFF. Two drops in one cycle add 2, saturating.
- Pop:
  - Occurs when trace_valid_o && trace_ready_i. Head advances by 1.
  - Pop and push (1 or 2) may occur in the same cycle: count_next = count + pushes - pop.
- Output timing:
  - First-word-fall-through. trace_valid_o = (count != 0).
  - Head fields are driven from storage at the head pointer. An entry written at edge N is visible after edge N.
  - With trace_valid_o = 0, head fields are don't-care; the bench checks them only when valid.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, so full (count == DEPTH) is distinguishable from empty.
- Reset or clear mid-drain discards all entries immediately. trace_valid_o = 0 the next cycle.
- Emitted entries keep program order: REG before HILO within a cycle, older cycles first.

Decomposition:
- Package wb_trace_pkg:
  - trace_kind_e (TRACE_NONE = 0, TRACE_REG = 1, TRACE_HILO = 2).
  - trace_entry_t struct {kind, wd, data[63:0], cycle}.
  - DROP_CNT_W = 16.
- Sub-module trace_fifo_2w1r:
  - Parametrised dual-push/single-pop FIFO storage of trace_entry_t.
  - Inputs: push0, push1, pop. Outputs: count, head.
- The top level keeps event qualification, drop/overflow accounting and the cycle counter.

Test Plan:
- Reset release, then REG write $1 = 0x00001100 at cycle 3, ready held 1 -> one entry: kind 1, wd 1, data 0x0000000000001100, cycle 3; valid for 1 cycle.
- wb_wreg_i = 1, wd = 0, data 0xFFFFFFFF -> no entry, overflow_o stays 0, drop_cnt_o stays 0.
- Same cycle REG $2 = 0x5 and HILO hi = 0x1, lo = 0x2, ready = 0 -> two entries: REG first, then HILO with data 0x0000000100000002; both carry an identical stamp.
- ready = 0, 17 single REG events with DEPTH = 16 -> 16 entries held, overflow_o = 1, drop_cnt_o = 1. Drained order matches write order.
- FIFO at count 15, ready = 0, REG + HILO in one cycle -> REG stored, HILO dropped, count = 16, drop_cnt_o increments by 1.
- FIFO full, ready = 1 and one REG event in the same cycle -> pop occurs, event dropped (no pass-through), count = 15. Then clear_i -> valid = 0, overflow_o = 0, drop_cnt_o = 0, next stamp = 0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared types and constants for the writeback commit-trace unit
//   TRACE_* kinds : what architectural write a trace entry records
//   trace_entry_t : one FIFO entry (kind, GPR index, payload, cycle stamp)
package wb_trace_pkg;
    localparam int DROP_CNT_W = 16;
    localparam int CYCLE_MAX_W = 64;
    typedef enum logic [1:0] {
        TRACE_NONE = 2'd0,
        TRACE_REG  = 2'd1,
        TRACE_HILO = 2'd2
    } trace_kind_e;
    // The stamp field is sized for the widest supported counter; narrower
    // counters are zero-extended on the way in and truncated on the way out.
    typedef struct packed {
        trace_kind_e            kind;
        logic [4:0]             wd;
        logic [63:0]            data;
        logic [CYCLE_MAX_W-1:0] cycle;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo_2w1r.sv
// trace_fifo_2w1r: trace-entry FIFO accepting up to two pushes and one pop per cycle
//   clk, rst, clear_i : clock, sync reset, sync flush
//   push0_i, data0_i  : first push, written at the tail
//   push1_i, data1_i  : second push, written at tail+1 (only together with push0_i)
//   pop_i             : advance the head (caller guarantees non-empty)
//   count_o           : number of stored entries, 0..DEPTH
//   head_o            : entry at the head pointer (first-word-fall-through)
module trace_fifo_2w1r
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         push0_i,
    input  logic         push1_i,
    input  logic         pop_i,
    input  trace_entry_t data0_i,
    input  trace_entry_t data1_i,
    output logic [AW:0]  count_o,
    output trace_entry_t head_o
);
    trace_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    always_comb begin
        wr_d = wr_q + AW'(push0_i) + AW'(push1_i);
        rd_d = rd_q + AW'(pop_i);
        count_d = count_q + (AW+1)'(push0_i) + (AW+1)'(push1_i) - (AW+1)'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
    // Storage is not reset: entries are only observable through count_q.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_q] <= data0_i;
        if (push1_i) mem_q[wr_q + AW'(1)] <= data1_i;
    end
    assign count_o = count_q;
    assign head_o = mem_q[rd_q];
endmodule

// File: rtl/wb_commit_trace.sv
// wb_commit_trace: captures writeback GPR and HI/LO commits into a cycle-stamped trace stream
//   clk, rst, clear_i        : clock, sync active-high reset, sync flush
//   wb_wreg_i/wd_i/wdata_i   : GPR write from writeback ($0 writes ignored)
//   wb_whilo_i/hi_i/lo_i     : HI/LO write from writeback
//   trace_valid_o/ready_i    : valid/ready handshake for the head entry
//   trace_kind/wd/data/cycle : head entry fields, zero while empty
//   overflow_o, drop_cnt_o   : sticky drop flag and saturating drop count
module wb_commit_trace
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYCLE_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  wb_wreg_i,
    input  logic [4:0]            wb_wd_i,
    input  logic [31:0]           wb_wdata_i,
    input  logic                  wb_whilo_i,
    input  logic [31:0]           wb_hi_i,
    input  logic [31:0]           wb_lo_i,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic [1:0]            trace_kind_o,
    output logic [4:0]            trace_wd_o,
    output logic [63:0]           trace_data_o,
    output logic [CYCLE_W-1:0]    trace_cycle_o,
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [DROP_CNT_W:0] drop_sum;
    logic ovf_q, ovf_d;
    logic reg_ev, hilo_ev;
    logic [1:0] n_ev, n_push, n_drop;
    logic [AW:0] count, free;
    trace_entry_t reg_e, hilo_e, head;
    always_comb begin
        reg_ev = wb_wreg_i && (wb_wd_i != 5'd0);
        hilo_ev = wb_whilo_i;
        n_ev = {1'b0, reg_ev} + {1'b0, hilo_ev};
        // Space is judged on the registered count: a same-cycle pop never makes room.
        free = (AW+1)'(DEPTH) - count;
        n_push = (free >= (AW+1)'(2)) ? n_ev : (free != '0 && n_ev != 2'd0) ? 2'd1 : 2'd0;
        n_drop = n_ev - n_push;
        reg_e = '{kind: TRACE_REG, wd: wb_wd_i, data: {32'h0, wb_wdata_i}, cycle: CYCLE_MAX_W'(cycle_q)};
        hilo_e = '{kind: TRACE_HILO, wd: 5'd0, data: {wb_hi_i, wb_lo_i}, cycle: CYCLE_MAX_W'(cycle_q)};
        drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(n_drop);
        drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        ovf_d = ovf_q || (n_drop != 2'd0);
        cycle_d = cycle_q + CYCLE_W'(1);
    end
    // With a single push the surviving event always goes in slot 0, so REG
    // (when present) precedes HILO and a lone HILO is never dropped for room it has.
    trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push0_i (n_push != 2'd0),
        .push1_i (n_push == 2'd2),
        .pop_i   (trace_valid_o && trace_ready_i),
        .data0_i (reg_ev ? reg_e : hilo_e),
        .data1_i (hilo_e),
        .count_o (count),
        .head_o  (head)
    );
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cycle_q <= '0;
            drop_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            drop_q <= drop_d;
            ovf_q <= ovf_d;
        end
    end
    assign trace_valid_o = (count != '0);
    assign trace_kind_o = trace_valid_o ? head.kind : TRACE_NONE;
    assign trace_wd_o = trace_valid_o ? head.wd : 5'd0;
    assign trace_data_o = trace_valid_o ? head.data : 64'd0;
    assign trace_cycle_o = trace_valid_o ? CYCLE_W'(head.cycle) : '0;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;
endmodule
